// File: rtl/dmem_access_unit.sv
// Memory-stage data access unit: one load/store per request over a wait-stated word bus.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete with an error.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dm_ctrl,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  function automatic size_e size_of(input logic [2:0] ctrl);
    case (ctrl)
      3'd1, 3'd2: return SzHalf;
      3'd3, 3'd4: return SzByte;
      default:    return SzWord;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] ctrl);
    return (ctrl == 3'd2) || (ctrl == 3'd4);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] ctrl);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size_of(ctrl))
      SzByte:  r = is_unsigned(ctrl) ? {24'b0, b} : {{24{b[7]}}, b};
      SzHalf:  r = is_unsigned(ctrl) ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  size_e             cap_size;
  logic [3:0]        cap_be;
  logic [31:0]       cap_wdata;
  logic              trap;
  logic              timeout;

  logic              we_q;
  logic [29:0]       addr_q;
  logic [1:0]        lo_q;
  logic [2:0]        ctrl_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Lane steering is resolved at capture so the bus side only sees registered values.
  always_comb begin
    cap_size  = size_of(cpu_dm_ctrl);
    cap_be    = 4'b1111;
    cap_wdata = cpu_wdata;
    case (cap_size)
      SzByte: begin
        cap_be    = 4'b0001 << cpu_addr[1:0];
        cap_wdata = {4{cpu_wdata[7:0]}};
      end
      SzHalf: begin
        cap_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        cap_wdata = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = ((cap_size == SzHalf) && cpu_addr[0]) ||
                ((cap_size == SzWord) && (cpu_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cpu_req) state_d = trap ? StResp : StIssue;
      StIssue: if (mem_ack || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == StIssue);
    mem_we    = (state_q == StIssue) & we_q;
    mem_be    = (state_q == StIssue) ? be_q : 4'b0000;
    mem_addr  = {addr_q, 2'b00};
    mem_wdata = wdata_q;
    cpu_ready = (state_q == StResp);
    cpu_rdata = rdata_q;
    cpu_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      lo_q    <= '0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr[31:2];
            lo_q    <= cpu_addr[1:0];
            ctrl_q  <= cpu_dm_ctrl;
            wdata_q <= cap_wdata;
            be_q    <= cap_be;
            cnt_q   <= '0;
            if (trap) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (mem_ack) begin
            // Store completions leave the previous load result untouched.
            if (!we_q) rdata_q <= load_extend(mem_rdata, lo_q, ctrl_q);
            err_q <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
